// File: rtl/axis_slip_decoder_pkg.sv
// SLIP framing constants and decoder state type shared by the deframer files.
package slip_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic {
        ST_NORMAL,
        ST_ESCAPED
    } slip_state_t;

endpackage

// File: rtl/axis_slip_decoder_if.sv
// AXI-Stream style channel bundle; DATA_W is 16 on the UART side and 8 on the packet side.
interface axis_slip_decoder_if #(
    parameter int DATA_W = 8
);

    logic [DATA_W-1:0] tdata;
    logic              tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata,
        output tuser,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tlast,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/axis_slip_decoder_out_reg.sv
// Single-entry output register for the SLIP deframer; its ready feeds straight back upstream.
module axis_slip_out_reg (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                i_push,
    input  logic [7:0]          i_data,
    input  logic                i_last,
    input  logic                i_user,
    output logic                o_ready,
    axis_slip_decoder_if.master m_axis
);

    logic       r_vld;
    logic [7:0] r_data;
    logic       r_last;
    logic       r_user;

    // A push is only ever issued while o_ready is high, so a stalled beat is never overwritten.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_vld  <= 1'b0;
            r_data <= 8'h00;
            r_last <= 1'b0;
            r_user <= 1'b0;
        end else if (i_push) begin
            r_vld  <= 1'b1;
            r_data <= i_data;
            r_last <= i_last;
            r_user <= i_user;
        end else if (m_axis.tready) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_ready       = ~r_vld | m_axis.tready;
    assign m_axis.tvalid = r_vld;
    assign m_axis.tdata  = r_data;
    assign m_axis.tlast  = r_last;
    assign m_axis.tuser  = r_user;

endmodule

// File: rtl/axis_slip_decoder.sv
// SLIP (RFC 1055) deframer: unescapes UART bytes into tlast-delimited packets with an error flag.
// Optional statistics counters are built only when SLIP_DECODER_STATS_EN is defined.
module axis_slip_decoder
    import slip_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1024,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axis_slip_decoder_if.slave   s_axis,
    axis_slip_decoder_if.master  m_axis,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] error_count
);

    localparam int LEN_W = $clog2(MAX_FRAME_LEN + 1);

    slip_state_t      r_state;
    slip_state_t      w_state_nxt;
    logic             r_hold_vld;
    logic [7:0]       r_hold_byte;
    logic             r_err;
    logic [LEN_W-1:0] r_len;

    logic             w_ready;
    logic             w_acc;
    logic [7:0]       w_byte;
    logic             w_is_data;
    logic             w_is_end;
    logic             w_esc_err;
    logic [7:0]       w_data;
    logic             w_overlen;
    logic             w_load;
    logic             w_err_now;
    logic             w_push;
    logic             w_unused;

    assign w_byte        = s_axis.tdata[7:0];
    assign w_acc         = s_axis.tvalid & w_ready;
    assign s_axis.tready = w_ready;
    assign w_unused      = ^{s_axis.tdata, s_axis.tlast};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            case (r_state)
                ST_NORMAL:  if (w_byte == SLIP_ESC) w_state_nxt = ST_ESCAPED;
                ST_ESCAPED: w_state_nxt = ST_NORMAL;
                default:    w_state_nxt = ST_NORMAL;
            endcase
        end
    end

    // Classify the accepted symbol; an escape followed by END still closes the frame.
    always_comb begin
        w_is_data = 1'b0;
        w_is_end  = 1'b0;
        w_esc_err = 1'b0;
        w_data    = w_byte;
        if (w_acc) begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_byte == SLIP_END) begin
                        w_is_end = 1'b1;
                    end else if (w_byte != SLIP_ESC) begin
                        w_is_data = 1'b1;
                    end
                end
                ST_ESCAPED: begin
                    if (w_byte == SLIP_ESC_END) begin
                        w_is_data = 1'b1;
                        w_data    = SLIP_END;
                    end else if (w_byte == SLIP_ESC_ESC) begin
                        w_is_data = 1'b1;
                        w_data    = SLIP_ESC;
                    end else if (w_byte == SLIP_END) begin
                        w_is_end  = 1'b1;
                        w_esc_err = 1'b1;
                    end else begin
                        w_esc_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_overlen = w_is_data & (r_len == LEN_W'(MAX_FRAME_LEN));
    assign w_load    = w_is_data & ~w_overlen;
    assign w_err_now = r_err | w_esc_err | (w_acc & s_axis.tuser) | w_overlen;
    assign w_push    = r_hold_vld & (w_load | w_is_end);

    // The hold register delays each byte until the next symbol tells us whether it ends the frame.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_hold_vld  <= 1'b0;
            r_hold_byte <= 8'h00;
            r_err       <= 1'b0;
            r_len       <= '0;
        end else if (w_is_end) begin
            r_hold_vld  <= 1'b0;
            r_err       <= 1'b0;
            r_len       <= '0;
        end else begin
            r_err <= w_err_now;
            if (w_load) begin
                r_hold_vld  <= 1'b1;
                r_hold_byte <= w_data;
                r_len       <= r_len + LEN_W'(1);
            end
        end
    end

    axis_slip_out_reg u_out_reg (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_push  (w_push),
        .i_data  (r_hold_byte),
        .i_last  (w_is_end),
        .i_user  (w_is_end & w_err_now),
        .o_ready (w_ready),
        .m_axis  (m_axis)
    );

`ifdef SLIP_DECODER_STATS_EN
    logic [CNT_WIDTH-1:0] r_frame_cnt;
    logic [CNT_WIDTH-1:0] r_error_cnt;

    // Errored empty frames count as errors even though nothing is emitted for them.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_frame_cnt <= '0;
            r_error_cnt <= '0;
        end else if (w_is_end) begin
            if (w_err_now) begin
                r_error_cnt <= r_error_cnt + CNT_WIDTH'(1);
            end else if (r_hold_vld) begin
                r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign frame_count = r_frame_cnt;
    assign error_count = r_error_cnt;
`else
    assign frame_count = '0;
    assign error_count = '0;
`endif

endmodule
